adc_trigger_seq: RTL
====================

# adc_trigger_seq

Parametrised multi-channel trigger sequencer: the next-generation ADC trigger source. From one base period counter it produces a one-cycle trigger pulse per channel, each delayed by a programmable per-channel phase offset. It supports continuous, counted-burst and externally armed burst modes. It sits between the AXI-Lite config registers and the ADC capture front ends, replacing the free-running single-output divider trigger.

## Interface
- `CNT_WIDTH`, 32: width of the period, offset and trigger-count fields.
- `NUM_CH`, 2: number of trigger output channels (≥1).
- `BURST_WIDTH`, 16: width of the burst length.
- `clk`  in  1  system clock (125 MHz nominal).
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `divider`  in  CNT_WIDTH  base period in clk cycles.
- `mode`  in  2  operating mode: 0 OFF, 1 CONT, 2 BURST, 3 EXT.
- `burst_len`  in  BURST_WIDTH  base ticks per burst (BURST/EXT).
- `offset`  in  NUM_CH*CNT_WIDTH  per-channel delay after the base tick; channel k is in bits [k*CNT_WIDTH +: CNT_WIDTH].
- `start`  in  1  single-cycle start request.
- `stop`  in  1  single-cycle abort request.
- `ext_trig`  in  1  asynchronous external arm edge.
- `trigger`  out  NUM_CH  one-cycle trigger pulses.
- `busy`  out  1  high while the sequencer is running or pulses are pending.
- `done`  out  1  one-cycle pulse when a burst completes normally.
- `trig_count`  out  CNT_WIDTH  base ticks issued since the last accepted start; saturating.
- `missed_ext`  out  1  sticky flag: an ext edge arrived while not in WAIT_EXT.

## Operation
- States: IDLE, WAIT_EXT, RUN, DRAIN.
- **Reset:** state IDLE; all outputs 0; all counters 0.
- **Accepted start:** `start` is high in IDLE, `mode`≠OFF, and `divider`≠0; for BURST/EXT, `burst_len`≠0 is also required. Any other start is ignored and causes no state change.
- **On an accepted start:**
  - `divider`, `burst_len`, `mode` and all offsets are latched; later input changes are ignored until the next start.
  - Each latched offset is clamped to divider−1.
  - `trig_count` and `missed_ext` are cleared.
- **Next state after an accepted start:** CONT/BURST go to RUN; EXT goes to WAIT_EXT.
- **WAIT_EXT:** `ext_trig` passes through a 2-FF synchroniser and rising-edge detect. A detected edge moves the block to RUN.
- **RUN:**
  - The base counter issues a tick on entry, then every `divider` cycles.
  - Each tick increments `trig_count`, saturating at all-ones.
- **Leaving RUN:**
  - In CONT, RUN continues until stop.
  - In BURST/EXT, after tick number `burst_len` the block moves to DRAIN.
- **DRAIN:** waits until every channel's pending delay has fired, then pulses `done` and returns to IDLE.
- **Channel k:**
  - A base tick loads delay counter k with offset[k].
  - `trigger[k]` pulses when the counter expires; offset 0 pulses in the same cycle as the tick.
  - Clamping guarantees at most one pending pulse per channel.
- **`busy`:** high in WAIT_EXT, RUN and DRAIN.
- **`stop`:** from any state, returns to IDLE on the next edge and cancels pending channel pulses. No `done` pulse is generated. If `stop` and `start` are high together, stop wins.
- **`missed_ext`:** set by a synchronised ext edge in IDLE, RUN or DRAIN; cleared only by an accepted start.
- **`divider`=1:** a tick every cycle; valid in all modes.

## Timing
- All outputs are registered.
- `start` sampled at edge n:
  - `busy` is high from edge n+1.
  - The first base tick is at edge n+1 (CONT/BURST).
  - Subsequent ticks are at n+1+i·divider.
- `trigger[k]` is high for exactly the cycle after edge (tick edge + offset[k]).
- EXT: an `ext_trig` rise sampled at edge m gives the first tick at edge m+3 (2-FF sync plus the edge register).
- `done` is high the cycle after the final channel pulse; `busy` falls at the same edge.
- `stop` sampled at edge n: `busy`=0 and `trigger`=0 from edge n+1.
- Asynchronous reset mid-burst clears everything immediately; no spurious pulse after release.

## Structure
- `adc_trigger_pkg` holds:
  - the `trig_mode_t` enum (OFF/CONT/BURST/EXT);
  - the `trig_state_t` enum;
  - the mode encoding constants shared with the register file.
- Sub-module `adc_trigger_delay`: a per-channel loadable down-counter with a single-pulse output. It is instantiated NUM_CH times in a generate loop.
- The top module holds the FSM, base counter, burst counter, ext synchroniser and saturating `trig_count`.

## Test plan
- CONT, divider=10, offsets {0,3}, start at edge 4:
  - trigger[0] at edges 5, 15, 25…; trigger[1] at edges 8, 18…;
  - stop at edge 40 → no pulses after edge 41, `busy`=0.
- BURST, divider=4, burst_len=3, offsets {0,5}:
  - offset[1] is clamped to 3;
  - trigger[0] at edges s+1, s+5, s+9; trigger[1] at edges s+4, s+8, s+12;
  - `done` at edge s+13; `trig_count`=3.
- EXT, burst_len=2, divider=6:
  - no pulse before `ext_trig`; `ext_trig` rise at edge m → ticks at m+3, m+9;
  - a second ext edge during RUN sets `missed_ext`.
- Illegal starts: divider=0, or BURST with burst_len=0 → `busy` stays 0 and no triggers. Start and stop in the same cycle → ignored.
- divider=1, CONT: trigger[0] high on every cycle; `trig_count` saturates with CNT_WIDTH=4 at 15.
- `resetn` asserted mid-burst with a channel pulse pending: all outputs 0 immediately; no pulse after release.

Source files
------------

// File: rtl/adc_trigger_pkg.sv
// Shared types for the ADC trigger sequencer and the register file that programs it.
// Mode encodings match the register field values.
package adc_trigger_pkg;

    localparam logic [1:0] MODE_ENC_OFF   = 2'd0;
    localparam logic [1:0] MODE_ENC_CONT  = 2'd1;
    localparam logic [1:0] MODE_ENC_BURST = 2'd2;
    localparam logic [1:0] MODE_ENC_EXT   = 2'd3;

    typedef enum logic [1:0] {
        MODE_OFF   = MODE_ENC_OFF,
        MODE_CONT  = MODE_ENC_CONT,
        MODE_BURST = MODE_ENC_BURST,
        MODE_EXT   = MODE_ENC_EXT
    } trig_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_EXT,
        ST_RUN,
        ST_DRAIN
    } trig_state_t;

endpackage

// File: rtl/adc_trigger_delay.sv
// Per-channel delay: a load arms a down-counter; the pulse fires value cycles after the load edge.
// A zero value pulses at the load edge itself; clear drops both the pending delay and the pulse.
module adc_trigger_delay #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] value,
    output logic                 pulse,
    output logic                 pending
);

    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            pending <= 1'b0;
            pulse   <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
            pulse   <= 1'b0;
        end else if (load) begin
            pulse   <= (value == '0);
            pending <= (value != '0);
            cnt     <= value - C_ONE;
        end else if (pending && cnt == '0) begin
            pulse   <= 1'b1;
            pending <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (pending)
                cnt <= cnt - C_ONE;
        end
    end

endmodule

// File: rtl/adc_trigger_seq.sv
// Multi-channel trigger sequencer: base period counter with per-channel phase delays.
// The accepting start (or detected ext edge) is itself the first base tick; all outputs are registered.
module adc_trigger_seq
    import adc_trigger_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int NUM_CH      = 2,
    parameter int BURST_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [CNT_WIDTH-1:0]        divider,
    input  logic [1:0]                  mode,
    input  logic [BURST_WIDTH-1:0]      burst_len,
    input  logic [NUM_CH*CNT_WIDTH-1:0] offset,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        ext_trig,
    output logic [NUM_CH-1:0]           trigger,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_WIDTH-1:0]        trig_count,
    output logic                        missed_ext
);

    localparam logic [CNT_WIDTH-1:0]   C_ONE = CNT_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] B_ONE = BURST_WIDTH'(1);

    trig_state_t                 state;
    trig_mode_t                  mode_in, mode_l, cur_mode;
    logic [CNT_WIDTH-1:0]        div_l, cur_div, base_cnt, tc_base, tc_next;
    logic [BURST_WIDTH-1:0]      len_l, cur_len, burst_cnt, burst_next;
    logic [NUM_CH*CNT_WIDTH-1:0] off_l, off_clamped;
    logic [NUM_CH-1:0]           pend;
    logic                        ext_s1, ext_s2, ext_s3, ext_edge;
    logic                        accept, tick, last_tick;

    assign mode_in  = trig_mode_t'(mode);
    assign ext_edge = ext_s2 & ~ext_s3;

    assign accept = (state == ST_IDLE) && start && !stop && (mode_in != MODE_OFF)
                    && (divider != '0) && (mode_in == MODE_CONT || burst_len != '0);

    // The accepting cycle already behaves as the first RUN cycle, so use the live inputs there.
    assign cur_mode = accept ? mode_in : mode_l;
    assign cur_div  = accept ? divider : div_l;
    assign cur_len  = accept ? burst_len : len_l;

    assign tick = !stop && ((accept && mode_in != MODE_EXT)
                            || (state == ST_WAIT_EXT && ext_edge)
                            || (state == ST_RUN && base_cnt == '0));

    assign burst_next = (accept ? '0 : burst_cnt) + B_ONE;
    assign last_tick  = tick && (cur_mode != MODE_CONT) && (burst_next == cur_len);
    assign tc_base    = accept ? '0 : trig_count;
    assign tc_next    = (tc_base == '1) ? tc_base : tc_base + C_ONE;

    // Clamping to divider-1 keeps each channel's delay shorter than the tick spacing.
    always_comb begin
        off_clamped = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (offset[k*CNT_WIDTH +: CNT_WIDTH] >= divider)
                off_clamped[k*CNT_WIDTH +: CNT_WIDTH] = divider - C_ONE;
            else
                off_clamped[k*CNT_WIDTH +: CNT_WIDTH] = offset[k*CNT_WIDTH +: CNT_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
            ext_s3 <= 1'b0;
        end else begin
            ext_s1 <= ext_trig;
            ext_s2 <= ext_s1;
            ext_s3 <= ext_s2;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            mode_l     <= MODE_OFF;
            div_l      <= '0;
            len_l      <= '0;
            off_l      <= '0;
            base_cnt   <= '0;
            burst_cnt  <= '0;
            trig_count <= '0;
            missed_ext <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ext_edge && state != ST_WAIT_EXT)
                missed_ext <= 1'b1;
            if (stop) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (accept) begin
                        mode_l     <= mode_in;
                        div_l      <= divider;
                        len_l      <= burst_len;
                        off_l      <= off_clamped;
                        burst_cnt  <= '0;
                        trig_count <= '0;
                        missed_ext <= 1'b0;
                        busy       <= 1'b1;
                        state      <= (mode_in == MODE_EXT) ? ST_WAIT_EXT : ST_RUN;
                    end
                    ST_WAIT_EXT: if (ext_edge) state <= ST_RUN;
                    ST_RUN: ;
                    ST_DRAIN: if (pend == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
                if (tick) begin
                    base_cnt   <= cur_div - C_ONE;
                    burst_cnt  <= burst_next;
                    trig_count <= tc_next;
                    if (last_tick)
                        state <= ST_DRAIN;
                end else if (state == ST_RUN) begin
                    base_cnt <= base_cnt - C_ONE;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        adc_trigger_delay #(.CNT_WIDTH(CNT_WIDTH)) u_delay (
            .clk     (clk),
            .resetn  (resetn),
            .clear   (stop),
            .load    (tick),
            .value   (accept ? off_clamped[k*CNT_WIDTH +: CNT_WIDTH] : off_l[k*CNT_WIDTH +: CNT_WIDTH]),
            .pulse   (trigger[k]),
            .pending (pend[k])
        );
    end

endmodule
